alu_arbiter: RTL

Shares one registered ALU between two requesters. Each request carries operands A, B and a 3-bit opcode. The block arbitrates round-robin, drives the ALU inputs, and holds them stable while the ALU registers Y and then captures ONZ. It returns Y, ONZ and the requester ID over a valid/ready response channel, and sits directly upstream of the ALU instance.

---
 rtl/alu_arbiter_pkg.sv | 30 +++
 rtl/alu_arbiter_rr_arbiter2.sv | 26 ++
 rtl/alu_arbiter.sv | 111 +++++++++++
 3 files changed

// File: rtl/alu_arbiter_pkg.sv
// Shared types and constants for the two-requester ALU arbiter.
// The opcode and flag-index constants are shared with the ALU and the bench.
package alu_arbiter_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        FLAG = 2'd2,
        RESP = 2'd3
    } state_t;

    localparam logic [2:0] OP_ADD  = 3'd0;
    localparam logic [2:0] OP_SUB  = 3'd1;
    localparam logic [2:0] OP_AND  = 3'd2;
    localparam logic [2:0] OP_OR   = 3'd3;
    localparam logic [2:0] OP_XOR  = 3'd4;
    localparam logic [2:0] OP_INC  = 3'd5;
    localparam logic [2:0] OP_MOVA = 3'd6;
    localparam logic [2:0] OP_MOVB = 3'd7;

    localparam int O = 2;
    localparam int N = 1;
    localparam int Z = 0;

    // Requester index carried by a one-hot two-way grant.
    function automatic logic grant_id(input logic [1:0] grant);
        return grant[1];
    endfunction

endpackage

// File: rtl/alu_arbiter_rr_arbiter2.sv
// Two-way round-robin grant logic; purely combinational.
// On a tie the requester that did not win last time is granted.
module rr_arbiter2 (
    input  logic [1:0] i_valid,
    input  logic       i_last_grant,
    output logic [1:0] o_grant
);

    // One-hot grant from the request vector and the previous winner.
    always_comb begin
        o_grant = 2'b00;
        case (i_valid)
            2'b01: o_grant = 2'b01;
            2'b10: o_grant = 2'b10;
            2'b11: begin
                if (i_last_grant) begin
                    o_grant = 2'b01;
                end else begin
                    o_grant = 2'b10;
                end
            end
            default: o_grant = 2'b00;
        endcase
    end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered ALU between two requesters. Operands stay held from
// the grant until the response handshake so the ALU's flag logic sees them.
module alu_arbiter
    import alu_arbiter_pkg::*;
#(
    parameter int width = 8
) (
    input  logic             clk,
    input  logic             rst_neg,
    input  logic             req0_valid,
    input  logic             req1_valid,
    output logic             req0_ready,
    output logic             req1_ready,
    input  logic [width-1:0] req0_a,
    input  logic [width-1:0] req0_b,
    input  logic [width-1:0] req1_a,
    input  logic [width-1:0] req1_b,
    input  logic [2:0]       req0_op,
    input  logic [2:0]       req1_op,
    output logic [width-1:0] alu_a,
    output logic [width-1:0] alu_b,
    output logic [2:0]       alu_op,
    output logic             alu_onz_en,
    output logic             alu_rst_pos,
    input  logic [width-1:0] alu_y,
    input  logic [2:0]       alu_onz,
    output logic             rsp_valid,
    input  logic             rsp_ready,
    output logic             rsp_id,
    output logic [width-1:0] rsp_y,
    output logic [2:0]       rsp_onz
);

    state_t     r_state;
    logic       r_last_grant;
    logic [1:0] w_grant;
    logic       w_idle;

    rr_arbiter2 u_rr_arbiter2 (
        .i_valid      ({req1_valid, req0_valid}),
        .i_last_grant (r_last_grant),
        .o_grant      (w_grant)
    );

    assign w_idle      = (r_state == IDLE);
    assign req0_ready  = w_idle & w_grant[0];
    assign req1_ready  = w_idle & w_grant[1];
    assign alu_rst_pos = 1'b0;

    // Results come straight from the ALU; they are stable because its inputs are held.
    assign rsp_y   = alu_y;
    assign rsp_onz = alu_onz;

    // Sequencer: grant, let the ALU register Y, then ONZ, then hold the response.
    always_ff @(posedge clk or negedge rst_neg) begin
        if (!rst_neg) begin
            r_state      <= IDLE;
            r_last_grant <= 1'b1;
            alu_a        <= {width{1'b0}};
            alu_b        <= {width{1'b0}};
            alu_op       <= 3'd0;
            alu_onz_en   <= 1'b0;
            rsp_valid    <= 1'b0;
            rsp_id       <= 1'b0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_grant != 2'b00) begin
                        r_state      <= EXEC;
                        r_last_grant <= grant_id(w_grant);
                        rsp_id       <= grant_id(w_grant);
                        if (w_grant[1]) begin
                            alu_a  <= req1_a;
                            alu_b  <= req1_b;
                            alu_op <= req1_op;
                        end else begin
                            alu_a  <= req0_a;
                            alu_b  <= req0_b;
                            alu_op <= req0_op;
                        end
                    end else begin
                        r_state <= IDLE;
                    end
                end
                EXEC: begin
                    r_state    <= FLAG;
                    alu_onz_en <= 1'b1;
                end
                FLAG: begin
                    r_state    <= RESP;
                    alu_onz_en <= 1'b0;
                    rsp_valid  <= 1'b1;
                end
                RESP: begin
                    if (rsp_ready) begin
                        r_state   <= IDLE;
                        rsp_valid <= 1'b0;
                    end else begin
                        r_state <= RESP;
                    end
                end
                default: begin
                    r_state    <= IDLE;
                    alu_onz_en <= 1'b0;
                    rsp_valid  <= 1'b0;
                end
            endcase
        end
    end

endmodule
